// File: rtl/bus_pkg.sv
// Shared system-bus definitions for the serial read-data path.
// Used by both the slave output port and the master input port.
package bus_pkg;

  localparam int BUS_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RECEIVE = 2'b01,
    HOLD    = 2'b10
  } rx_state_t;

endpackage

// File: rtl/serial_shift_in.sv
// LSB-first serial deserialiser: writes bit_in into word[cnt] on each enabled edge.
// The counter clears itself after the last bit, so it never wraps.
module serial_shift_in #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word,
  output logic             last_bit
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (en) begin
      word[cnt] <= bit_in;
      cnt       <= last_bit ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/master_in_port.sv
// Master-side serial receiver: deserialises one word per transfer, checks the
// slave's end-of-word strobe, and buffers the word behind a valid/ready handshake.
module master_in_port
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slave_valid,
  output logic                  master_ready,
  input  logic                  rx_data,
  input  logic                  slave_tx_done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_error,
  input  logic                  err_clear
);

  rx_state_t             state, state_nxt;
  logic                  sh_en, bad_state, last_bit, frm_bad;
  logic [DATA_WIDTH-1:0] word, word_full;

  serial_shift_in #(.WIDTH(DATA_WIDTH)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .en       (sh_en),
    .clr      (bad_state),
    .bit_in   (rx_data),
    .word     (word),
    .last_bit (last_bit)
  );

  assign master_ready = (state == IDLE);
  assign frm_bad      = (state == RECEIVE) && (slave_tx_done != last_bit);

  always_comb begin
    state_nxt = state;
    sh_en     = 1'b0;
    bad_state = 1'b0;
    case (state)
      IDLE: begin
        if (slave_valid) begin
          sh_en     = 1'b1;
          state_nxt = RECEIVE;
        end
      end
      RECEIVE: begin
        sh_en = 1'b1;
        if (last_bit) state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        bad_state = 1'b1;
      end
    endcase
  end

  // The top bit arrives on the same edge the word is captured, so bypass it in.
  always_comb begin
    word_full                 = word;
    word_full[DATA_WIDTH-1]   = rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset || bad_state) begin
      state       <= IDLE;
      data_out    <= '0;
      out_valid   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RECEIVE && last_bit) begin
        data_out  <= word_full;
        out_valid <= 1'b1;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
      if (frm_bad)        frame_error <= 1'b1;
      else if (err_clear) frame_error <= 1'b0;
    end
  end

endmodule
